alu_cmd_issuer: RTL and testbench

//  Command front-end for myalu. Buffers (A,B,opcode,tag) commands from a valid/ready

---
 rtl/alu_cmd_issuer.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, issues one per cycle to myalu, returns results in order.
// Latency: push at edge t -> issue t+1 -> ALU result registered t+2 -> rsp_valid after t+3.
// Backpressure: cmd_ready drops when the command FIFO is full; issue is credit-throttled so ALU results always fit.

// Generic circular FIFO used for both the command and response queues.
// Latency: a push becomes visible at the head the cycle after the write edge.
// Backpressure: push is ignored when full (even with a same-cycle pop); pop is ignored when empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != FULL_C);
    assign do_pop  = pop && (cnt != '0);
    assign pop_dat = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count; storage clears so the head reads zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// alu_cmd_issuer: command front-end for myalu with in-order tagged responses and sticky overflow.
// Latency: 3 edges from command push to rsp_valid; 1 response/cycle sustained with rsp_ready=1.
// Backpressure: cmd_ready follows command FIFO fullness; issue stalls until the response FIFO can absorb every in-flight result.
module alu_cmd_issuer #(
    parameter int NUMBITS   = 16,
    parameter int TAGBITS   = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUMBITS-1:0] cmd_a,
    input  logic [NUMBITS-1:0] cmd_b,
    input  logic [2:0]         cmd_opcode,
    input  logic [TAGBITS-1:0] cmd_tag,
    output logic               alu_reset,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic               rsp_carryout,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic [TAGBITS-1:0] rsp_tag,
    output logic               sticky_ovf,
    input  logic               sticky_clr,
    output logic               busy
);
    typedef struct packed {
        logic [TAGBITS-1:0] tag;
        logic [2:0]         opcode;
        logic [NUMBITS-1:0] b;
        logic [NUMBITS-1:0] a;
    } cmd_t;

    typedef struct packed {
        logic [TAGBITS-1:0] tag;
        logic               carryout;
        logic               overflow;
        logic               zero;
        logic [NUMBITS-1:0] result;
    } rsp_t;

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
    localparam logic [RCW:0]   RSP_LIM  = (RCW+1)'(RSP_DEPTH);

    cmd_t           cmd_in;
    cmd_t           cmd_head;
    logic [CCW-1:0] cmd_cnt;
    logic           cmd_push;
    logic           cmd_nonempty;

    rsp_t           rsp_in;
    rsp_t           rsp_head;
    logic [RCW-1:0] rsp_cnt;
    logic           rsp_pop;
    logic [RCW:0]   rsp_occ;

    logic               issue;
    logic               s1;
    logic               s2;
    logic [TAGBITS-1:0] tag_s1;
    logic [TAGBITS-1:0] tag_s2;

    assign alu_reset    = ~reset;
    assign cmd_ready    = reset && (cmd_cnt != CMD_FULL);
    assign cmd_push     = cmd_valid && cmd_ready;
    assign cmd_nonempty = (cmd_cnt != '0);

    assign rsp_valid = (rsp_cnt != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Response slots already spoken for after this edge: queued + both pipeline stages, minus the departing head.
    assign rsp_occ = {1'b0, rsp_cnt} + {{RCW{1'b0}}, s1} + {{RCW{1'b0}}, s2} - {{RCW{1'b0}}, rsp_pop};
    assign issue   = cmd_nonempty && (rsp_occ < RSP_LIM);

    assign busy = cmd_nonempty | s1 | s2 | rsp_valid;

    assign rsp_result   = rsp_head.result;
    assign rsp_carryout = rsp_head.carryout;
    assign rsp_overflow = rsp_head.overflow;
    assign rsp_zero     = rsp_head.zero;
    assign rsp_tag      = rsp_head.tag;

    // Pack the incoming command and the ALU outputs into queue entries.
    always_comb begin
        cmd_in          = '0;
        cmd_in.a        = cmd_a;
        cmd_in.b        = cmd_b;
        cmd_in.opcode   = cmd_opcode;
        cmd_in.tag      = cmd_tag;
        rsp_in          = '0;
        rsp_in.result   = alu_result;
        rsp_in.carryout = alu_carryout;
        rsp_in.overflow = alu_overflow;
        rsp_in.zero     = alu_zero;
        rsp_in.tag      = tag_s2;
    end

    alu_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_push),
        .push_dat (cmd_in),
        .pop      (issue),
        .pop_dat  (cmd_head),
        .cnt      (cmd_cnt)
    );

    // The credit rule keeps a slot free whenever s2 is set, so this push is never refused.
    alu_cmd_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (s2),
        .push_dat (rsp_in),
        .pop      (rsp_pop),
        .pop_dat  (rsp_head),
        .cnt      (rsp_cnt)
    );

    // Issue stage: load the FIFO head into the ALU operand registers; operands hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            tag_s1     <= '0;
            s1         <= 1'b0;
        end else begin
            s1 <= issue;
            if (issue) begin
                alu_a      <= cmd_head.a;
                alu_b      <= cmd_head.b;
                alu_opcode <= cmd_head.opcode;
                tag_s1     <= cmd_head.tag;
            end
        end
    end

    // Result stage: follows the ALU's own output register one edge behind the issue stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2     <= 1'b0;
            tag_s2 <= '0;
        end else begin
            s2     <= s1;
            tag_s2 <= tag_s1;
        end
    end

    // Sticky overflow: a captured overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_ovf <= 1'b0;
        end else if (s2 && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural myalu, scoreboard of expected responses, directed and random traffic.
// Inputs driven 1 time unit after posedge; handshakes and outputs sampled at negedge or posedge+1.
// Every wait is bounded; the run ends with a single pass/total summary line.
module tb_alu_cmd_issuer;
    localparam int CD = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [2:0]  cmd_opcode;
    logic [3:0]  cmd_tag;
    logic        alu_reset;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_carryout;
    logic        alu_overflow;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;
    logic        sticky_ovf;
    logic        sticky_clr;
    logic        busy;

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_opcode   (cmd_opcode),
        .cmd_tag      (cmd_tag),
        .alu_reset    (alu_reset),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_tag      (rsp_tag),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr),
        .busy         (busy)
    );

    // myalu stand-in: returns {carryout, overflow, zero, result}.
    function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        logic        v;
        w = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd2: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[15:0];
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a | b);
            default: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        endcase
        return {c, v, (r == 16'd0), r};
    endfunction

    // One-cycle registered ALU, cleared by its active-high reset.
    always @(posedge clk or posedge alu_reset) begin
        if (alu_reset) {alu_carryout, alu_overflow, alu_zero, alu_result} <= '0;
        else           {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_fn(alu_a, alu_b, alu_opcode);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: expected {tag, c, v, z, result} per accepted command, in acceptance order.
    logic [22:0] exp_q[$];
    logic [18:0] mon_f;
    int          n_push = 0;
    int          n_pop  = 0;
    int          n_ovf  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (cmd_valid && cmd_ready) begin
                mon_f = alu_fn(cmd_a, cmd_b, cmd_opcode);
                exp_q.push_back({cmd_tag, mon_f});
                n_push++;
                if (mon_f[17]) n_ovf++;
            end
            if (rsp_valid && rsp_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check("rsp", {9'd0, rsp_tag, rsp_carryout, rsp_overflow, rsp_zero, rsp_result},
                           {9'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic [3:0] tag);
        bit acc;
        int g;
        acc        = 1'b0;
        g          = 0;
        cmd_valid  = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        cmd_opcode = op;
        cmd_tag    = tag;
        while (!acc && g < 300) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            g++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 300) begin
            tick();
            g++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int lat;
    int run;
    int seen;
    int p0;
    int q0;
    int o0;
    bit rnd_done;

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_opcode = '0;
        cmd_tag    = '0;
        rsp_ready  = 1'b0;
        sticky_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_alu_reset", 32'(alu_reset), 32'd1);
        check("rst_alu_ops", {13'd0, alu_opcode, alu_a}, 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_rsp_dat", {9'd0, rsp_tag, rsp_carryout, rsp_overflow, rsp_zero, rsp_result}, 32'd0);

        reset = 1'b1;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        check("alu_reset_rel", 32'(alu_reset), 32'd0);

        // Single add: 3 edges from push to rsp_valid
        rsp_ready = 1'b1;
        push(16'h0003, 16'h0005, 3'd0, 4'd1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        wait_idle();

        // Carry-out and zero
        push(16'hFFFF, 16'h0001, 3'd0, 4'd2);
        wait_idle();
        check("sticky_no_ovf", 32'(sticky_ovf), 32'd0);

        // Overflow sets sticky until a clear pulse
        push(16'h7FFF, 16'h0001, 3'd1, 4'd3);
        wait_idle();
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        tick();
        check("sticky_hold", 32'(sticky_ovf), 32'd1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("sticky_cleared", 32'(sticky_ovf), 32'd0);

        // Back-to-back: 8 pushes give 8 consecutive response cycles
        run = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'(i));
            end
            begin
                int g;
                g = 0;
                while (!rsp_valid && g < 40) begin
                    tick();
                    g++;
                end
                while (rsp_valid && run < 20) begin
                    run++;
                    tick();
                end
            end
        join
        check("b2b_run", 32'(run), 32'd8);
        wait_idle();
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stalled consumer: both FIFOs fill, nothing lost once released
        rsp_ready = 1'b0;
        p0 = n_push;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'(i));
            end
            begin
                repeat (25) tick();
                check("stall_accepted", 32'(n_push - p0), 32'(CD + RD));
                check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
                check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                check("stall_head", {9'd0, rsp_tag, rsp_carryout, rsp_overflow, rsp_zero, rsp_result},
                      {9'd0, exp_q[0]});
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        check("stall_total", 32'(n_push - p0), 32'd10);
        check("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset with work in flight discards everything
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'(i));
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_alu", {13'd0, alu_opcode, alu_a}, 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) tick();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("post_rst_no_rsp", 32'(seen), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Random traffic with a randomly stalling consumer
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        p0 = n_push;
        q0 = n_pop;
        o0 = n_ovf;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    push(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        check("rnd_accepted", 32'(n_push - p0), 32'd60);
        check("rnd_delivered", 32'(n_pop - q0), 32'd60);
        check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_sticky", 32'(sticky_ovf), 32'(n_ovf != o0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
